// File: rtl/spi_tx_word.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_tx_word
// Purpose  : SPI mode-0 master transmitter for DATA_W-bit words, with a
//            programmable SCLK divider, MSB- or LSB-first bit order, and
//            chaining of several words under one CS assertion.
// Ports    : i_clk, i_rst  - clock and synchronous active-high reset
//            i_data, i_we  - word and write strobe (taken only when o_ready=1)
//            i_keep        - hold CS low after this word for a following one
//            i_miso        - serial input (used only with SPI_RX_EN)
//            o_data        - MOSI
//            o_sclk        - SPI clock, idles low
//            o_cs          - chip select, active low
//            o_ready       - a write can be accepted this cycle
//            o_done        - one-cycle pulse per completed word
//            o_rdata       - received word (zero unless SPI_RX_EN)
// Options  : `define SPI_RX_EN to enable the MISO receive shift register.
// Revision : 1.0 - initial release
// ============================================================================
module spi_tx_word #(
    parameter int DATA_W    = 8,
    parameter int DIV       = 1,
    parameter int WAIT      = 10,
    parameter int LSB_FIRST = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_we,
    input  logic              i_keep,
    input  logic              i_miso,
    output logic              o_data,
    output logic              o_sclk,
    output logic              o_cs,
    output logic              o_ready,
    output logic              o_done,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int c_BIT_W  = $clog2(DATA_W);
    localparam int c_DIV_W  = (DIV  > 1) ? $clog2(DIV)  : 1;
    localparam int c_WAIT_W = (WAIT > 1) ? $clog2(WAIT) : 1;
    localparam logic [c_BIT_W-1:0]  c_BIT_LAST  = c_BIT_W'(DATA_W - 1);
    localparam logic [c_DIV_W-1:0]  c_DIV_LAST  = c_DIV_W'(DIV - 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(WAIT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SHIFT = 3'd1,
        S_CHAIN = 3'd2,
        S_GAP   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_shreg;
    logic                r_keep;
    logic                r_started;   // first SHIFT cycle drives CS and bit 0
    logic [c_BIT_W-1:0]  r_bit_cnt;
    logic [c_DIV_W-1:0]  r_div_cnt;
    logic [c_WAIT_W-1:0] r_wait_cnt;

    logic              w_cur_bit;
    logic              w_next_bit;
    logic [DATA_W-1:0] w_shifted;
    logic              w_div_last;
    logic              w_bit_last;
    logic              w_wait_last;

    assign w_div_last  = (r_div_cnt == c_DIV_LAST);
    assign w_bit_last  = (r_bit_cnt == c_BIT_LAST);
    assign w_wait_last = (r_wait_cnt == c_WAIT_LAST);

    generate
        if (LSB_FIRST != 0) begin : g_lsb_first
            assign w_cur_bit  = r_shreg[0];
            assign w_next_bit = r_shreg[1];
            assign w_shifted  = {1'b0, r_shreg[DATA_W-1:1]};
        end else begin : g_msb_first
            assign w_cur_bit  = r_shreg[DATA_W-1];
            assign w_next_bit = r_shreg[DATA_W-2];
            assign w_shifted  = {r_shreg[DATA_W-2:0], 1'b0};
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_shreg    <= '0;
            r_keep     <= 1'b0;
            r_started  <= 1'b0;
            r_bit_cnt  <= '0;
            r_div_cnt  <= '0;
            r_wait_cnt <= '0;
            o_data     <= 1'b0;
            o_sclk     <= 1'b0;
            o_cs       <= 1'b1;
            o_ready    <= 1'b1;
            o_done     <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (r_state)
                S_IDLE, S_CHAIN: begin
                    if (i_we) begin
                        r_shreg   <= i_data;
                        r_keep    <= i_keep;
                        r_started <= 1'b0;
                        r_bit_cnt <= '0;
                        r_div_cnt <= '0;
                        o_ready   <= 1'b0;
                        r_state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (!r_started) begin
                        r_started <= 1'b1;
                        o_cs      <= 1'b0;
                        o_sclk    <= 1'b0;
                        o_data    <= w_cur_bit;
                    end else if (w_div_last) begin
                        r_div_cnt <= '0;
                        if (!o_sclk) begin
                            o_sclk <= 1'b1;
                        end else if (w_bit_last) begin
                            // High phase of the last bit has ended.
                            o_sclk <= 1'b0;
                            if (r_keep) begin
                                o_done  <= 1'b1;
                                o_ready <= 1'b1;
                                r_state <= S_CHAIN;
                            end else begin
                                o_cs       <= 1'b1;
                                r_wait_cnt <= '0;
                                r_state    <= S_GAP;
                            end
                        end else begin
                            // Falling SCLK: advance to the next bit.
                            o_sclk    <= 1'b0;
                            r_shreg   <= w_shifted;
                            o_data    <= w_next_bit;
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (w_wait_last) begin
                        o_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    o_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef SPI_RX_EN
    logic [DATA_W-1:0] r_rx;
    logic [DATA_W-1:0] w_rx_next;
    logic              w_rise;
    logic              w_done_set;

    // Same cycles on which the main FSM raises SCLK / raises o_done.
    assign w_rise     = (r_state == S_SHIFT) && r_started && w_div_last && !o_sclk;
    assign w_done_set = ((r_state == S_SHIFT) && r_started && w_div_last && o_sclk &&
                         w_bit_last && r_keep) ||
                        ((r_state == S_GAP) && w_wait_last);

    generate
        if (LSB_FIRST != 0) begin : g_rx_lsb_first
            assign w_rx_next = {i_miso, r_rx[DATA_W-1:1]};
        end else begin : g_rx_msb_first
            assign w_rx_next = {r_rx[DATA_W-2:0], i_miso};
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rx    <= '0;
            o_rdata <= '0;
        end else begin
            if (w_rise) begin
                r_rx <= w_rx_next;
            end
            if (w_done_set) begin
                o_rdata <= r_rx;
            end
        end
    end
`else
    logic w_unused_miso;
    assign w_unused_miso = i_miso;
    assign o_rdata       = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_tx_word.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_spi_tx_word
// Purpose  : Self-checking bench for spi_tx_word. Instance A: DATA_W=8,
//            DIV=1, WAIT=10, MSB first. Instance B: DATA_W=8, DIV=3, WAIT=4,
//            LSB first. Expected bit streams and edge timings are computed
//            from the word value and the transfer timing formulas.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_tx_word;

`ifdef SPI_RX_EN
    localparam bit C_RX = 1'b1;
`else
    localparam bit C_RX = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst   [2];
    logic       we    [2];
    logic       kp_in [2];
    logic       miso  [2];
    logic [7:0] din   [2];
    logic [7:0] mw    [2];
    logic       cs    [2];
    logic       sclk  [2];
    logic       mosi  [2];
    logic       rdy   [2];
    logic       done  [2];
    logic [7:0] rdata [2];

    int n_checks = 0;
    int n_errors = 0;

    spi_tx_word #(.DATA_W(8), .DIV(1), .WAIT(10), .LSB_FIRST(0)) u_dut_a (
        .i_clk(clk), .i_rst(rst[0]), .i_data(din[0]), .i_we(we[0]), .i_keep(kp_in[0]),
        .i_miso(miso[0]), .o_data(mosi[0]), .o_sclk(sclk[0]), .o_cs(cs[0]),
        .o_ready(rdy[0]), .o_done(done[0]), .o_rdata(rdata[0])
    );

    spi_tx_word #(.DATA_W(8), .DIV(3), .WAIT(4), .LSB_FIRST(1)) u_dut_b (
        .i_clk(clk), .i_rst(rst[1]), .i_data(din[1]), .i_we(we[1]), .i_keep(kp_in[1]),
        .i_miso(miso[1]), .o_data(mosi[1]), .o_sclk(sclk[1]), .o_cs(cs[1]),
        .o_ready(rdy[1]), .o_done(done[1]), .o_rdata(rdata[1])
    );

    // Mode-0 slave: presents bit 0 when CS is high, advances on each SCLK fall.
    logic [2:0] sidx0 = 3'd0;
    logic [2:0] sidx1 = 3'd0;
    logic       sq0   = 1'b0;
    logic       sq1   = 1'b0;

    always @(cs[0] or sclk[0]) begin
        if (cs[0] !== 1'b0) sidx0 = 3'd0;
        else if (sq0 && !sclk[0]) sidx0 = sidx0 + 3'd1;
        sq0 = sclk[0];
    end

    always @(cs[1] or sclk[1]) begin
        if (cs[1] !== 1'b0) sidx1 = 3'd0;
        else if (sq1 && !sclk[1]) sidx1 = sidx1 + 3'd1;
        sq1 = sclk[1];
    end

    assign miso[0] = mw[0][3'd7 - sidx0];
    assign miso[1] = mw[1][sidx1];

    function automatic int div_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic int wait_of(input int k);
        return (k == 0) ? 10 : 4;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One word: write it, then watch every edge up to the expected end and
    // compare the observed stream/timing against the reference formulas.
    task automatic do_word(input int k, input logic [7:0] d, input logic kp,
                           input logic [7:0] m, input bit poke, input bit chained);
        int dv, t_done, t_end, nrise, done_at, done_cnt, cs_low, wcnt;
        bit timing_ok, stable_ok, ready_ok, ready_exp;
        logic [7:0] obs_bits, exp_bits, rd;
        logic psclk, pdata, cs_first;
        dv        = div_of(k);
        t_done    = kp ? 1 + 16 * dv : 1 + 16 * dv + wait_of(k);
        t_end     = kp ? t_done : t_done + 1;
        nrise     = 0;
        done_at   = -1;
        done_cnt  = 0;
        cs_low    = 0;
        timing_ok = 1'b1;
        stable_ok = 1'b1;
        ready_ok  = 1'b1;
        obs_bits  = 8'h00;
        rd        = 8'h00;
        cs_first  = 1'b1;
        for (int i = 0; i < 8; i++) exp_bits[i] = (k == 1) ? d[i] : d[7 - i];

        wcnt = 0;
        while (rdy[k] !== 1'b1 && wcnt < 400) begin
            @(posedge clk); #1;
            wcnt++;
        end
        chk("ready_before_write", 32'(rdy[k]), 1);
        mw[k] = m; din[k] = d; kp_in[k] = kp; we[k] = 1'b1;
        @(posedge clk); #1;
        we[k] = 1'b0;
        chk("cs_at_accept", 32'(cs[k]), chained ? 0 : 1);
        psclk = sclk[k];
        pdata = mosi[k];

        for (int e = 1; e <= t_end; e++) begin
            @(posedge clk); #1;
            if (poke && (e == 3 || e == t_done - 2)) begin
                we[k] = 1'b1; din[k] = 8'($urandom); kp_in[k] = 1'($urandom);
            end else begin
                we[k] = 1'b0;
            end
            if (e == 1) cs_first = cs[k];
            if (cs[k] === 1'b0) cs_low++;
            if (sclk[k] === 1'b1 && psclk === 1'b0) begin
                if (e != 1 + dv + 2 * dv * nrise) timing_ok = 1'b0;
                if (nrise < 8) obs_bits[nrise] = mosi[k];
                nrise++;
            end
            if (mosi[k] !== pdata && !(psclk === 1'b1 && sclk[k] === 1'b0) && e != 1)
                stable_ok = 1'b0;
            if (done[k] === 1'b1) begin
                done_cnt++;
                done_at = e;
                rd = rdata[k];
            end
            ready_exp = (e > t_done) || (kp && e == t_done);
            if (rdy[k] !== ready_exp) ready_ok = 1'b0;
            psclk = sclk[k];
            pdata = mosi[k];
        end
        we[k] = 1'b0;

        chk("mosi_bits", 32'(obs_bits), 32'(exp_bits));
        chk("sclk_rise_count", 32'(nrise), 8);
        chk("sclk_phase_timing", 32'(timing_ok), 1);
        chk("mosi_stable", 32'(stable_ok), 1);
        chk("ready_profile", 32'(ready_ok), 1);
        chk("cs_low_at_edge1", 32'(cs_first), 0);
        chk("cs_low_cycles", 32'(cs_low), kp ? 16 * dv + 1 : 16 * dv);
        chk("done_edge", 32'(done_at), 32'(t_done));
        chk("done_pulses", 32'(done_cnt), 1);
        chk("sclk_idle_low", 32'(sclk[k]), 0);
        chk("rdata", 32'(rd), C_RX ? 32'(m) : 0);
    endtask

    task automatic reset_mid(input int k);
        int n;
        we[k] = 1'b1; din[k] = 8'h96; kp_in[k] = 1'b0;
        @(posedge clk); #1;
        we[k] = 1'b0;
        repeat (1 + 8 * div_of(k)) @(posedge clk);   // start of bit 4
        #1;
        rst[k] = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_cs", 32'(cs[k]), 1);
        chk("rst_mid_sclk", 32'(sclk[k]), 0);
        chk("rst_mid_ready", 32'(rdy[k]), 1);
        chk("rst_mid_done", 32'(done[k]), 0);
        rst[k] = 1'b0;
        n = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done[k] === 1'b1) n++;
        end
        chk("rst_mid_no_done", 32'(n), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nw;
        int kk;
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; we[k] = 1'b0; kp_in[k] = 1'b0; din[k] = 8'h00; mw[k] = 8'h00;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("reset_cs", 32'(cs[k]), 1);
            chk("reset_sclk", 32'(sclk[k]), 0);
            chk("reset_mosi", 32'(mosi[k]), 0);
            chk("reset_done", 32'(done[k]), 0);
            chk("reset_ready", 32'(rdy[k]), 1);
            chk("reset_rdata", 32'(rdata[k]), 0);
        end
        rst[0] = 1'b0; rst[1] = 1'b0;
        @(posedge clk); #1;

        // Single words on both configurations.
        do_word(0, 8'hA5, 1'b0, 8'hC3, 1'b0, 1'b0);
        do_word(1, 8'h01, 1'b0, 8'hC3, 1'b0, 1'b0);

        // Three-word chain under one CS.
        do_word(0, 8'h2A, 1'b1, 8'h5A, 1'b0, 1'b0);
        do_word(0, 8'h00, 1'b1, 8'hC3, 1'b0, 1'b1);
        do_word(0, 8'hFF, 1'b0, 8'h81, 1'b0, 1'b1);

        // Writes attempted while busy are ignored.
        do_word(0, 8'h6B, 1'b0, 8'h33, 1'b1, 1'b0);
        do_word(1, 8'hD4, 1'b0, 8'h0F, 1'b1, 1'b0);

        // Reset together with a write: the write is dropped.
        rst[0] = 1'b1; we[0] = 1'b1; din[0] = 8'hFF; kp_in[0] = 1'b0;
        @(posedge clk); #1;
        rst[0] = 1'b0; we[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_with_we_cs", 32'(cs[0]), 1);
        chk("rst_with_we_ready", 32'(rdy[0]), 1);

        // Reset in the middle of a word, then a clean transfer.
        reset_mid(0);
        do_word(0, 8'h3C, 1'b0, 8'hC3, 1'b0, 1'b0);
        reset_mid(1);
        do_word(1, 8'h3C, 1'b0, 8'hC3, 1'b0, 1'b0);

        // Random chains on random instances.
        for (int t = 0; t < 8; t++) begin
            kk = int'($urandom_range(0, 1));
            nw = int'($urandom_range(1, 3));
            for (int j = 0; j < nw; j++)
                do_word(kk, 8'($urandom), (j != nw - 1), 8'($urandom),
                        1'($urandom_range(0, 1)), (j != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_tx_word.md
# spi_tx_word

Parametrised SPI master transmitter, the successor to the fixed 8-bit serialiser. It shifts words of DATA_W bits out on MOSI and generates its own SCLK (mode 0) at a programmable divide ratio. It supports MSB- or LSB-first order, and chains words under one CS assertion for multi-byte LCD/SD commands. It sits between the command sequencer and the SPI pins.

## Interface
- DATA_W, 8, word width in bits; legal range 2..32.
- DIV, 1, SCLK half-period in i_clk cycles; must be ≥1.
- WAIT, 10, CS-high guard cycles after the final word of a transfer; must be ≥1.
- LSB_FIRST, 0, bit order: 0 = MSB first, 1 = LSB first.

Ports:
- i_clk  in  1  system clock; all logic is on the rising edge.
- i_rst  in  1  reset; synchronous and active-high.
- i_data  in  DATA_W  word to send; sampled only when a write is accepted.
- i_we  in  1  write strobe; accepted only while o_ready=1.
- i_keep  in  1  sampled with i_we; 1 = keep CS low after this word and wait for the next one.
- i_miso  in  1  serial input; used only with SPI_RX_EN.
- o_data  out  1  MOSI.
- o_sclk  out  1  SPI clock; idles low.
- o_cs  out  1  chip select, active low.
- o_ready  out  1  block can accept i_we this cycle.
- o_done  out  1  one-cycle pulse per completed word.
- o_rdata  out  DATA_W  received word; valid from the o_done pulse until the next word completes.

## Operation
- All outputs are registered.
- Reset values: o_cs=1, o_sclk=0, o_data=0, o_done=0, o_ready=1, o_rdata=0, state IDLE.
- IDLE
  - o_ready=1.
  - On i_we: load the shift register from i_data, latch i_keep, clear the bit and divide counters, go to SHIFT.
- SHIFT
  - o_cs=0; o_data carries the current bit (bit DATA_W-1 first, or bit 0 if LSB_FIRST).
  - Each bit is DIV cycles with o_sclk=0, then DIV cycles with o_sclk=1.
  - The shift register advances when o_sclk falls (1→0).
  - After the high phase of the last bit:
    - Latched keep=1: go to CHAIN, pulse o_done.
    - Latched keep=0: go to GAP; o_cs=1, o_sclk=0.
- CHAIN
  - o_cs stays 0, o_sclk=0, o_ready=1.
  - On i_we: load the word and keep flag as in IDLE, go to SHIFT.
  - With no i_we, CHAIN waits indefinitely with CS held low. Only i_we with i_keep=0, or reset, releases it.
- GAP
  - o_cs=1, o_ready=0; count WAIT cycles, then go to DONE.
- DONE
  - o_done=1 for one cycle, o_ready=0, then go to IDLE.
- Boundary rules:
  - i_we while o_ready=0 is ignored; i_data is not sampled and no error is flagged.
  - i_we on the same cycle as i_rst: reset wins and the word is dropped.
  - i_rst mid-transfer: on the next edge o_cs=1, o_sclk=0, and no o_done is emitted.
  - Counter widths are sized with $clog2 of DATA_W, DIV and WAIT; no wrap occurs within the legal ranges.

## Timing
- i_we accepted at edge 0:
  - o_cs falls and the first bit appears at edge 1.
  - o_cs stays low for exactly 2·DIV·DATA_W cycles for a single word.
- Single word: o_done asserts at edge 1 + 2·DIV·DATA_W + WAIT; o_ready returns one edge later.
  - Example, DATA_W=8, DIV=1, WAIT=10: CS low for cycles 1–16, o_done at 27, o_ready at 28.
- Chained word:
  - o_done and o_ready assert at edge 1 + 2·DIV·DATA_W.
  - The next word's first bit appears one edge after its accepted i_we, so the minimum CS-low inter-word idle is 1 cycle.
- MOSI changes only when o_sclk falls, or at the start of a word. It is stable for the full high phase, so the slave samples on SCLK rise.

## Configuration
- SPI_RX_EN defined:
  - i_miso is sampled on the cycle o_sclk rises and shifted in using the same bit order as TX.
  - o_rdata updates in the same cycle as each word's o_done.
- SPI_RX_EN undefined:
  - The port remains but i_miso is ignored.
  - o_rdata is constant 0 and no RX register is synthesised.

## Test plan
- Reset, then single word DATA_W=8, DIV=1, WAIT=10, i_data=8'hA5, i_keep=0:
  - MOSI bits 1,0,1,0,0,1,0,1 sampled on 8 SCLK rises.
  - CS low for 16 cycles; o_done at edge 27; o_ready at 28.
- DIV=3, LSB_FIRST=1, i_data=8'h01:
  - First bit is 1; SCLK high and low phases are each 3 cycles.
  - CS low for 48 cycles.
- Chain 3 words 8'h2A, 8'h00, 8'hFF with i_keep=1,1,0:
  - CS is never high between words; three o_done pulses.
  - CS rises only after the third word, followed by the WAIT gap.
- i_we pulses during SHIFT and GAP: ignored; the MOSI stream is unchanged and no extra o_done pulse occurs.
- i_rst asserted mid-word at bit 4, with no i_we on the same cycle:
  - Next edge: o_cs=1, o_sclk=0, o_ready=1, and no o_done.
  - A following write of 8'h3C transmits correctly.
- With SPI_RX_EN, i_miso driven with 8'hC3 (bit order as configured): o_rdata=8'hC3 at the o_done pulse. Without the macro: o_rdata=0.
